// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the instruction sequencer and the CPU datapath/memory.
// Latency: none, wires only.
// Backpressure: memory stalls the sequencer by holding mem_ready low while mem_req is high.
interface multicycle_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             alu_zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic             rf_we;
  logic             link;
  logic [2:0]       state;
  logic             fault;
  logic [CNT_W-1:0] retired;

  // Sequencer side: consumes status, drives datapath enables and the memory request.
  modport master (
    input  run, op, funct, alu_zero, mem_ready,
    output mem_req, mem_we, ir_we, pc_we, pc_src, rf_we, link, state, fault, retired
  );

  // Datapath/memory side.
  modport slave (
    output run, op, funct, alu_zero, mem_ready,
    input  mem_req, mem_we, ir_we, pc_we, pc_src, rf_we, link, state, fault, retired
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FSM sequencing fetch/decode/exec/mem/writeback for one instruction at a time.
// Latency: beq/jal 3, R-type/ori/sw 4, lw 5 cycles with zero-wait memory.
// Backpressure: FETCH/MEM hold mem_req until mem_ready; TIMEOUT cycles without ready -> ERR.
module multicycle_sequencer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam int              WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [2:0]        insn_done_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  retired;
  logic              retire;
  logic              is_rtype;
  logic              funct_ok;
  logic              legal;
  logic              wait_last;

  logic              mem_req;
  logic              mem_we;
  logic              ir_we;
  logic              pc_we;
  logic [1:0]        pc_src;
  logic              rf_we;
  logic              link;
  logic              fault;

  assign is_rtype      = (bus.op == OP_RTYPE);
  assign funct_ok      = (bus.funct == FN_SLL) || (bus.funct == FN_ADD) || (bus.funct == FN_ADDU) ||
                         (bus.funct == FN_SUB) || (bus.funct == FN_SUBU);
  assign legal         = (is_rtype && funct_ok) || (bus.op == OP_ORI) || (bus.op == OP_LW) ||
                         (bus.op == OP_SW) || (bus.op == OP_BEQ) || (bus.op == OP_JAL);
  assign wait_last     = (wait_cnt == WAIT_LAST);
  // run is only looked at once an instruction has fully retired.
  assign insn_done_nxt = bus.run ? S_FETCH : S_IDLE;

  // Next-state and retire decode.
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_IDLE:   if (bus.run) state_nxt = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready)  state_nxt = S_DECODE;
        else if (wait_last) state_nxt = S_ERR;
      end
      S_DECODE: state_nxt = legal ? S_EXEC : S_ERR;
      S_EXEC: begin
        if (is_rtype || bus.op == OP_ORI) begin
          state_nxt = S_WB;
        end else if (bus.op == OP_LW || bus.op == OP_SW) begin
          state_nxt = S_MEM;
        end else if (bus.op == OP_BEQ || bus.op == OP_JAL) begin
          retire    = 1'b1;
          state_nxt = insn_done_nxt;
        end else begin
          state_nxt = S_ERR;
        end
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (bus.op == OP_SW) begin
            retire    = 1'b1;
            state_nxt = insn_done_nxt;
          end else begin
            state_nxt = S_WB;
          end
        end else if (wait_last) begin
          state_nxt = S_ERR;
        end
      end
      S_WB: begin
        retire    = 1'b1;
        state_nxt = insn_done_nxt;
      end
      S_ERR:    state_nxt = S_ERR;
      default:  state_nxt = S_ERR;
    endcase
  end

  // Datapath enables, decoded from state so everything is low in IDLE and under reset.
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_src  = 2'b00;
    rf_we   = 1'b0;
    link    = 1'b0;
    fault   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = bus.mem_ready;
        pc_we   = bus.mem_ready;
      end
      S_EXEC: begin
        if (bus.op == OP_BEQ) begin
          pc_we  = bus.alu_zero;
          pc_src = 2'b01;
        end else if (bus.op == OP_JAL) begin
          pc_we  = 1'b1;
          pc_src = 2'b10;
          rf_we  = 1'b1;
          link   = 1'b1;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (bus.op == OP_SW);
      end
      S_WB:    rf_we = 1'b1;
      S_ERR:   fault = 1'b1;
      default: ;
    endcase
  end

  // State register; ERR is only escaped through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Memory wait counter: restarts on every state change, counts stalled request cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      wait_cnt <= '0;
    else if (state_nxt != state)     wait_cnt <= '0;
    else if (mem_req && !bus.mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

  assign bus.mem_req = mem_req;
  assign bus.mem_we  = mem_we;
  assign bus.ir_we   = ir_we;
  assign bus.pc_we   = pc_we;
  assign bus.pc_src  = pc_src;
  assign bus.rf_we   = rf_we;
  assign bus.link    = link;
  assign bus.fault   = fault;
  assign bus.state   = state;
  assign bus.retired = retired;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-instruction vector table plus corner sequences.
// Latency: n/a.
// Backpressure: memory ready is scripted per vector (wait cycles in FETCH and MEM).
module tb_multicycle_sequencer;

  localparam int CNT_W = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_MEM   = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd6;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         fw;    // cycles without ready in FETCH
    int         mw;    // cycles without ready in MEM
    int         cyc;
    int         req;
    int         we;
    int         ir;
    int         pc;
    int         mask;  // bit n set if pc_we seen with pc_src==n
    int         rf;
    int         link;
    int         ret;
    int         flt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   cyc, n_req, n_we, n_ir, n_pc, src_mask, n_rf, n_link;
  vec_t vq[$];

  multicycle_sequencer_if #(.CNT_W(CNT_W)) bus ();

  multicycle_sequencer #(.TIMEOUT(4), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic vec_t mk(logic [5:0] o, logic [5:0] f, logic z, int fw, int mw, int c,
                              int rq, int w, int ir, int pc, int m, int rf, int lk, int rt, int fl);
    vec_t v;
    v.op = o; v.funct = f; v.zero = z; v.fw = fw; v.mw = mw; v.cyc = c; v.req = rq; v.we = w;
    v.ir = ir; v.pc = pc; v.mask = m; v.rf = rf; v.link = lk; v.ret = rt; v.flt = fl;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.run       = 1'b0;
    bus.op        = 6'h00;
    bus.funct     = 6'h00;
    bus.alu_zero  = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Starts one instruction from IDLE, drops run once in FETCH, tallies enables until IDLE or ERR.
  task automatic exec_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input int fw, input int mw);
    int       wctr;
    logic [2:0] prev;
    cyc = 0; n_req = 0; n_we = 0; n_ir = 0; n_pc = 0; src_mask = 0; n_rf = 0; n_link = 0;
    bus.op = o; bus.funct = f; bus.alu_zero = z; bus.run = 1'b1; bus.mem_ready = 1'b0;
    @(negedge clk);
    bus.run = 1'b0;
    wctr = 0;
    prev = S_IDLE;
    while (bus.state != S_IDLE && bus.state != S_ERR && cyc < 64) begin
      if (bus.state != prev) wctr = 0;
      if (bus.state == S_FETCH)    bus.mem_ready = (wctr >= fw);
      else if (bus.state == S_MEM) bus.mem_ready = (wctr >= mw);
      else                         bus.mem_ready = 1'b1;  // must be ignored without mem_req
      #1;
      cyc++;
      n_req  += int'(bus.mem_req);
      n_we   += int'(bus.mem_we);
      n_ir   += int'(bus.ir_we);
      n_rf   += int'(bus.rf_we);
      n_link += int'(bus.link);
      if (bus.pc_we) begin
        n_pc++;
        src_mask |= (1 << bus.pc_src);
      end
      wctr++;
      prev = bus.state;
      @(negedge clk);
    end
    bus.mem_ready = 1'b0;
  endtask

  initial begin
    int acc;
    tests = 0;
    fails = 0;

    //        op     funct  z  fw mw cyc req we ir pc msk rf lk ret flt
    vq.push_back(mk(6'h00, 6'h20, 0, 0, 0, 4, 1, 0, 1, 1, 1, 1, 0, 1, 0)); // add
    vq.push_back(mk(6'h00, 6'h21, 0, 0, 0, 4, 1, 0, 1, 1, 1, 1, 0, 1, 0)); // addu
    vq.push_back(mk(6'h00, 6'h22, 0, 0, 0, 4, 1, 0, 1, 1, 1, 1, 0, 1, 0)); // sub
    vq.push_back(mk(6'h00, 6'h23, 0, 0, 0, 4, 1, 0, 1, 1, 1, 1, 0, 1, 0)); // subu
    vq.push_back(mk(6'h00, 6'h00, 0, 0, 0, 4, 1, 0, 1, 1, 1, 1, 0, 1, 0)); // sll
    vq.push_back(mk(6'h0D, 6'h3F, 0, 0, 0, 4, 1, 0, 1, 1, 1, 1, 0, 1, 0)); // ori, funct ignored
    vq.push_back(mk(6'h23, 6'h00, 0, 0, 0, 5, 2, 0, 1, 1, 1, 1, 0, 1, 0)); // lw
    vq.push_back(mk(6'h2B, 6'h00, 0, 0, 0, 4, 2, 1, 1, 1, 1, 0, 0, 1, 0)); // sw
    vq.push_back(mk(6'h04, 6'h00, 1, 0, 0, 3, 1, 0, 1, 2, 3, 0, 0, 1, 0)); // beq taken
    vq.push_back(mk(6'h04, 6'h00, 0, 0, 0, 3, 1, 0, 1, 1, 1, 0, 0, 1, 0)); // beq not taken
    vq.push_back(mk(6'h03, 6'h00, 0, 0, 0, 3, 1, 0, 1, 2, 5, 1, 1, 1, 0)); // jal, run dropped
    vq.push_back(mk(6'h3F, 6'h00, 0, 0, 0, 2, 1, 0, 1, 1, 1, 0, 0, 0, 1)); // illegal op
    vq.push_back(mk(6'h02, 6'h00, 0, 0, 0, 2, 1, 0, 1, 1, 1, 0, 0, 0, 1)); // j not supported
    vq.push_back(mk(6'h00, 6'h24, 0, 0, 0, 2, 1, 0, 1, 1, 1, 0, 0, 0, 1)); // R-type and: illegal
    vq.push_back(mk(6'h23, 6'h00, 0, 0, 3, 8, 5, 0, 1, 1, 1, 1, 0, 1, 0)); // lw, 3 wait in MEM
    vq.push_back(mk(6'h00, 6'h20, 0, 4, 0, 4, 4, 0, 0, 0, 0, 0, 0, 0, 1)); // fetch timeout
    vq.push_back(mk(6'h00, 6'h20, 0, 3, 0, 7, 4, 0, 1, 1, 1, 1, 0, 1, 0)); // ready on last cycle
    vq.push_back(mk(6'h2B, 6'h00, 0, 0, 4, 7, 5, 4, 1, 1, 1, 0, 0, 0, 1)); // sw MEM timeout
    vq.push_back(mk(6'h2B, 6'h00, 0, 0, 3, 7, 5, 4, 1, 1, 1, 0, 0, 1, 0)); // sw ready on last cycle

    // Reset state, with run and mem_ready already high.
    rst_n = 1'b0;
    bus.run = 1'b1; bus.op = 6'h23; bus.funct = 6'h00; bus.alu_zero = 1'b1; bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_state", 0, bus.state, S_IDLE);
    check("rst_retired", 0, bus.retired, 0);
    check("rst_fault", 0, bus.fault, 0);
    acc = int'(bus.mem_req) + int'(bus.mem_we) + int'(bus.ir_we) + int'(bus.pc_we) +
          int'(bus.rf_we) + int'(bus.link) + int'(bus.pc_src);
    check("rst_enables", 0, acc, 0);
    // Idle with run low: stray mem_ready must do nothing.
    bus.run = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_state", 0, bus.state, S_IDLE);
    check("idle_ir_we", 0, bus.ir_we, 0);

    for (int i = 0; i < vq.size(); i++) begin
      do_reset();
      exec_instr(vq[i].op, vq[i].funct, vq[i].zero, vq[i].fw, vq[i].mw);
      check("cycles", i, cyc, vq[i].cyc);
      check("mem_req_cyc", i, n_req, vq[i].req);
      check("mem_we_cyc", i, n_we, vq[i].we);
      check("ir_we_cnt", i, n_ir, vq[i].ir);
      check("pc_we_cnt", i, n_pc, vq[i].pc);
      check("pc_src_mask", i, src_mask, vq[i].mask);
      check("rf_we_cnt", i, n_rf, vq[i].rf);
      check("link_cnt", i, n_link, vq[i].link);
      check("retired", i, bus.retired, vq[i].ret);
      check("fault", i, bus.fault, vq[i].flt);
      check("end_state", i, bus.state, (vq[i].flt != 0) ? S_ERR : S_IDLE);
    end

    // ERR is sticky: run and mem_ready high change nothing until reset.
    do_reset();
    exec_instr(6'h3F, 6'h00, 1'b0, 0, 0);
    bus.run = 1'b1; bus.mem_ready = 1'b1; bus.op = 6'h00; bus.funct = 6'h20;
    acc = 0;
    repeat (6) begin
      @(negedge clk);
      acc += int'(bus.mem_req) + int'(bus.ir_we) + int'(bus.pc_we) + int'(bus.rf_we) +
             int'(bus.state != S_ERR) + int'(!bus.fault);
    end
    check("err_sticky", 0, acc, 0);
    rst_n = 1'b0;
    #1;
    check("err_rst_state", 0, bus.state, S_IDLE);
    check("err_rst_fault", 0, bus.fault, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted while sw waits in MEM: request drops at once.
    do_reset();
    bus.op = 6'h2B; bus.run = 1'b1; bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.run = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check("mem_state", 0, bus.state, S_MEM);
    check("mem_req_held", 0, bus.mem_req, 1);
    check("mem_we_held", 0, bus.mem_we, 1);
    #1;
    rst_n = 1'b0;
    #1;
    acc = int'(bus.mem_req) + int'(bus.mem_we) + int'(bus.ir_we) + int'(bus.pc_we) + int'(bus.rf_we);
    check("midmem_rst_enables", 0, acc, 0);
    check("midmem_rst_state", 0, bus.state, S_IDLE);
    check("midmem_rst_retired", 0, bus.retired, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back adds with run held: 15 retired after 61 cycles, then drop run and wrap to 0.
    do_reset();
    bus.op = 6'h00; bus.funct = 6'h20; bus.run = 1'b1; bus.mem_ready = 1'b1;
    repeat (61) @(negedge clk);
    check("b2b_retired", 0, bus.retired, 15);
    check("b2b_state", 0, bus.state, S_FETCH);
    bus.run = 1'b0;
    repeat (4) @(negedge clk);
    check("wrap_retired", 0, bus.retired, 0);
    check("wrap_state", 0, bus.state, S_IDLE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
